// File: rtl/door_actuator_model_pkg.sv
// Shared encodings for the sliding-door plant model: state codes, fault codes and the
// motor command decode. The door-control FSM uses the same encodings.
package door_actuator_model_pkg;

    // Reported door state, 3-bit code visible on the state output.
    typedef enum logic [2:0] {
        StClosed  = 3'd0,
        StOpen    = 3'd1,
        StOpening = 3'd2,
        StClosing = 3'd3,
        StStopped = 3'd4,
        StFault   = 3'd5
    } door_state_e;

    // Sticky fault code; none means the plant follows motor commands.
    typedef enum logic [1:0] {
        FaultNone     = 2'b00,
        FaultConflict = 2'b01,
        FaultStall    = 2'b10
    } door_fault_e;

    // Decoded motor command.
    typedef enum logic [1:0] {
        CmdNone     = 2'b00,
        CmdOpen     = 2'b01,
        CmdClose    = 2'b10,
        CmdConflict = 2'b11
    } door_cmd_e;

    // Both motor lines high at once is a controller bug, reported as a conflict.
    function automatic door_cmd_e decode_cmd(input logic motor_open, input logic motor_close);
        door_cmd_e cmd;
        unique case ({motor_close, motor_open})
            2'b00:   cmd = CmdNone;
            2'b01:   cmd = CmdOpen;
            2'b10:   cmd = CmdClose;
            default: cmd = CmdConflict;
        endcase
        return cmd;
    endfunction

    // True when the command actually asks the door to move.
    function automatic logic is_motion(input door_cmd_e cmd);
        return (cmd == CmdOpen) || (cmd == CmdClose);
    endfunction

endpackage

// File: rtl/door_step_prescaler.sv
// Step prescaler: produces one tick on the PRESCALE-th consecutive enabled edge on which the
// plant is driven in the same direction. A restart makes the current edge count as the first.
module door_step_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena_i,
    input  logic run_i,      // count this edge
    input  logic clr_i,      // synchronous clear, wins over run
    input  logic restart_i,  // direction change: discard count, this edge is the first
    output logic tick_o
);

    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic [CntW-1:0] cnt_base;

    // Next count and tick; a restart behaves as if the count had been cleared beforehand.
    always_comb begin
        cnt_base = restart_i ? '0 : cnt_q;
        tick_o   = run_i && !clr_i && (cnt_base == CntLast);
        cnt_d    = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = tick_o ? '0 : cnt_base + CntW'(1);
        end
    end

    // Count register; holds whenever the block is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ena_i) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/door_actuator_model.sv
// Cycle-based plant model of the sliding door: turns motor commands into position, limit
// switches, reported state and sticky conflict/stall faults.
module door_actuator_model
    import door_actuator_model_pkg::*;
#(
    parameter int unsigned TRAVEL      = 15,
    parameter int unsigned POS_W       = 4,
    parameter int unsigned PRESCALE    = 4,
    parameter int unsigned STALL_STEPS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_i,
    input  logic             motor_open_i,
    input  logic             motor_close_i,
    input  logic             obstruct_i,
    input  logic             fault_clr_i,
    output logic             lim_open_o,
    output logic             lim_closed_o,
    output logic [POS_W-1:0] pos_o,
    output logic [2:0]       state_o,
    output logic [1:0]       fault_code_o
);

    localparam int unsigned StallW = $clog2(STALL_STEPS + 1);
    localparam logic [POS_W-1:0]  PosMax    = POS_W'(TRAVEL);
    localparam logic [StallW-1:0] StallLast = StallW'(STALL_STEPS - 1);

    logic [POS_W-1:0]  pos_q,   pos_d;
    logic [StallW-1:0] stall_q, stall_d;
    door_fault_e       fault_q, fault_d;
    door_state_e       state_q, state_d;
    door_cmd_e         dir_q,   dir_d;   // last non-conflict command, for direction changes

    door_cmd_e         cmd;
    logic              faulted;
    logic              dir_change;
    logic              can_move;
    logic              presc_run;
    logic              presc_clr;
    logic              tick;
    logic [StallW-1:0] stall_base;

    // Command decode and prescaler control.
    always_comb begin
        cmd        = decode_cmd(motor_open_i, motor_close_i);
        faulted    = (fault_q != FaultNone);
        dir_change = ((cmd == CmdOpen) && (dir_q == CmdClose)) ||
                     ((cmd == CmdClose) && (dir_q == CmdOpen));
        can_move   = ((cmd == CmdOpen) && (pos_q < PosMax)) ||
                     ((cmd == CmdClose) && (pos_q != '0));
        // Conflict neither runs nor clears, so the count is frozen on that edge.
        presc_run  = !faulted && is_motion(cmd);
        presc_clr  = faulted || (cmd == CmdNone);
    end

    door_step_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena_i     (ena_i),
        .run_i     (presc_run),
        .clr_i     (presc_clr),
        .restart_i (dir_change),
        .tick_o    (tick)
    );

    // Next-state for position, stall counter and fault.
    always_comb begin
        pos_d      = pos_q;
        stall_d    = stall_q;
        fault_d    = fault_q;
        dir_d      = (cmd == CmdConflict) ? dir_q : cmd;
        stall_base = dir_change ? '0 : stall_q;

        if (faulted) begin
            // Sticky: only an explicit clear with the motor idle releases it.
            if (fault_clr_i && (cmd == CmdNone)) begin
                fault_d = FaultNone;
                stall_d = '0;
            end
        end else begin
            unique case (cmd)
                CmdConflict: fault_d = FaultConflict;
                CmdNone:     stall_d = '0;
                default: begin
                    stall_d = stall_base;
                    if (tick) begin
                        if (can_move && !obstruct_i) begin
                            pos_d   = (cmd == CmdOpen) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                            stall_d = '0;
                        end else begin
                            stall_d = stall_base + StallW'(1);
                            if (stall_base >= StallLast) begin
                                fault_d = FaultStall;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Reported state, evaluated on the next-state position and fault.
    always_comb begin
        if (fault_d != FaultNone) begin
            state_d = StFault;
        end else if ((cmd == CmdOpen) && (pos_d < PosMax)) begin
            state_d = StOpening;
        end else if ((cmd == CmdClose) && (pos_d != '0)) begin
            state_d = StClosing;
        end else if (pos_d == '0) begin
            state_d = StClosed;
        end else if (pos_d == PosMax) begin
            state_d = StOpen;
        end else begin
            state_d = StStopped;
        end
    end

    // Plant registers; everything holds while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q   <= '0;
            stall_q <= '0;
            fault_q <= FaultNone;
            state_q <= StClosed;
            dir_q   <= CmdNone;
        end else if (ena_i) begin
            pos_q   <= pos_d;
            stall_q <= stall_d;
            fault_q <= fault_d;
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    // Limit switches decode straight from the position register.
    always_comb begin
        lim_open_o   = (pos_q == PosMax);
        lim_closed_o = (pos_q == '0);
        pos_o        = pos_q;
        state_o      = state_q;
        fault_code_o = fault_q;
    end

endmodule

// File: tb/tb_door_actuator_model.sv
// Self-checking bench for door_actuator_model: an edge-level door model built from run lengths
// of identical commands, compared against the DUT every cycle, plus literal checkpoints.
module tb_door_actuator_model;

    localparam int TRAVEL      = 15;
    localparam int POS_W       = 4;
    localparam int PRESCALE    = 4;
    localparam int STALL_STEPS = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b1;
    logic             m_open = 1'b0;
    logic             m_close = 1'b0;
    logic             obstruct = 1'b0;
    logic             fault_clr = 1'b0;
    logic             lim_open;
    logic             lim_closed;
    logic [POS_W-1:0] pos;
    logic [2:0]       state;
    logic [1:0]       fault_code;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: position, length of current same-command run, blocked steps, fault, state.
    int e_pos, e_run, e_last, e_blocked, e_fault, e_state, e_cmd;

    door_actuator_model #(
        .TRAVEL      (TRAVEL),
        .POS_W       (POS_W),
        .PRESCALE    (PRESCALE),
        .STALL_STEPS (STALL_STEPS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena_i         (ena),
        .motor_open_i  (m_open),
        .motor_close_i (m_close),
        .obstruct_i    (obstruct),
        .fault_clr_i   (fault_clr),
        .lim_open_o    (lim_open),
        .lim_closed_o  (lim_closed),
        .pos_o         (pos),
        .state_o       (state),
        .fault_code_o  (fault_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Door model: 0 none, 1 open, 2 close, 3 both.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_pos = 0; e_run = 0; e_last = 0; e_blocked = 0; e_fault = 0; e_state = 0;
        end else if (ena) begin
            e_cmd = (m_open ? 1 : 0) + (m_close ? 2 : 0);
            if (e_fault != 0) begin
                e_run = 0;
                if (fault_clr && e_cmd == 0) begin
                    e_fault = 0;
                    e_blocked = 0;
                end
            end else if (e_cmd == 3) begin
                e_fault = 1;
            end else if (e_cmd == 0) begin
                e_run = 0;
                e_blocked = 0;
            end else begin
                if (e_last != 0 && e_last != e_cmd) begin
                    e_run = 0;
                    e_blocked = 0;
                end
                e_run++;
                if (e_run == PRESCALE) begin
                    e_run = 0;
                    if (!obstruct && ((e_cmd == 1 && e_pos < TRAVEL) ||
                                      (e_cmd == 2 && e_pos > 0))) begin
                        e_pos = (e_cmd == 1) ? e_pos + 1 : e_pos - 1;
                        e_blocked = 0;
                    end else begin
                        e_blocked++;
                        if (e_blocked >= STALL_STEPS) e_fault = 2;
                    end
                end
            end
            if (e_cmd != 3) e_last = e_cmd;
            if (e_fault != 0) e_state = 5;
            else if (e_cmd == 1 && e_pos < TRAVEL) e_state = 2;
            else if (e_cmd == 2 && e_pos > 0) e_state = 3;
            else if (e_pos == 0) e_state = 0;
            else if (e_pos == TRAVEL) e_state = 1;
            else e_state = 4;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("cyc_pos", int'(pos), e_pos);
            chk("cyc_lim_open", int'(lim_open), (e_pos == TRAVEL) ? 1 : 0);
            chk("cyc_lim_closed", int'(lim_closed), (e_pos == 0) ? 1 : 0);
            chk("cyc_state", int'(state), e_state);
            chk("cyc_fault", int'(fault_code), e_fault);
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cmd(input logic o, input logic c);
        m_open  = o;
        m_close = c;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_pos", int'(pos), 0);
        chk("rst_lim_closed", int'(lim_closed), 1);
        chk("rst_lim_open", int'(lim_open), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_fault", int'(fault_code), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Full open, then stall at the open limit
        set_cmd(1'b1, 1'b0);
        run(3);
        chk("open_3_pos", int'(pos), 0);
        run(1);
        chk("open_4_pos", int'(pos), 1);
        chk("open_4_lc", int'(lim_closed), 0);
        chk("open_4_state", int'(state), 2);
        run(56);
        chk("open_60_pos", int'(pos), 15);
        chk("open_60_lo", int'(lim_open), 1);
        chk("open_60_state", int'(state), 1);
        run(11);
        chk("stall_71_fault", int'(fault_code), 0);
        run(1);
        chk("stall_72_fault", int'(fault_code), 2);
        chk("stall_72_state", int'(state), 5);
        chk("stall_72_pos", int'(pos), 15);
        // Clear with a motor line high is ignored
        fault_clr = 1'b1;
        run(1);
        chk("clr_ignored", int'(fault_code), 2);
        set_cmd(1'b0, 1'b0);
        run(1);
        fault_clr = 1'b0;
        chk("clr_fault", int'(fault_code), 0);
        chk("clr_state_open", int'(state), 1);

        // Conflict from closed
        reset_pulse();
        set_cmd(1'b1, 1'b1);
        run(1);
        chk("conf_fault", int'(fault_code), 1);
        chk("conf_pos", int'(pos), 0);
        chk("conf_state", int'(state), 5);
        set_cmd(1'b0, 1'b0);
        fault_clr = 1'b1;
        run(1);
        fault_clr = 1'b0;
        chk("conf_clr_fault", int'(fault_code), 0);
        chk("conf_clr_state", int'(state), 0);

        // Partial open, stop, close back
        set_cmd(1'b1, 1'b0);
        run(28);
        chk("half_pos", int'(pos), 7);
        set_cmd(1'b0, 1'b0);
        run(1);
        chk("stop_state", int'(state), 4);
        run(3);
        chk("stop_pos", int'(pos), 7);
        set_cmd(1'b0, 1'b1);
        run(27);
        chk("close_27_pos", int'(pos), 1);
        run(1);
        chk("close_28_pos", int'(pos), 0);
        chk("close_28_state", int'(state), 0);
        set_cmd(1'b0, 1'b0);
        run(1);

        // Direction change mid-prescale restarts the count on that edge
        set_cmd(1'b1, 1'b0);
        run(6);
        chk("rev_open_pos", int'(pos), 1);
        set_cmd(1'b0, 1'b1);
        run(3);
        chk("rev_3_pos", int'(pos), 1);
        run(1);
        chk("rev_4_pos", int'(pos), 0);
        set_cmd(1'b0, 1'b0);
        run(1);

        // Obstruction stall at pos 5
        set_cmd(1'b1, 1'b0);
        run(20);
        chk("obs_start_pos", int'(pos), 5);
        obstruct = 1'b1;
        run(12);
        chk("obs_pos", int'(pos), 5);
        chk("obs_fault", int'(fault_code), 2);
        set_cmd(1'b0, 1'b0);
        obstruct = 1'b0;
        fault_clr = 1'b1;
        run(1);
        fault_clr = 1'b0;
        chk("obs_clr", int'(fault_code), 0);

        // Enable low freezes position and prescaler
        set_cmd(1'b1, 1'b0);
        run(2);
        ena = 1'b0;
        run(10);
        chk("ena_hold_pos", int'(pos), 5);
        ena = 1'b1;
        run(2);
        chk("ena_resume_pos", int'(pos), 6);
        run(12);
        chk("pre_rst_pos", int'(pos), 9);

        // Asynchronous reset mid-travel
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pos", int'(pos), 0);
        chk("async_lc", int'(lim_closed), 1);
        chk("async_state", int'(state), 0);
        #1;
        set_cmd(1'b0, 1'b0);
        rst_n = 1'b1;
        run(3);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
